// File: rtl/reg_selfcheck_engine.sv
// Register self-check sequencer: runs the core until halt or a cycle budget expires,
// then compares a table of expected register values through a register-file read port.
module reg_selfcheck_engine #(
   parameter int XLEN       = 64,
   parameter int NUM_CHECKS = 5,
   parameter int AW         = 5,
   parameter int MAX_CYCLES = 500,
   parameter int RD_LAT     = 1,
   parameter int IDXW       = $clog2(NUM_CHECKS + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       halt,
   input  logic [NUM_CHECKS*AW-1:0]   chk_reg,
   input  logic [NUM_CHECKS*XLEN-1:0] chk_val,
   output logic [AW-1:0]              rf_raddr,
   input  logic [XLEN-1:0]            rf_rdata,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic                       timed_out,
   output logic [IDXW-1:0]            err_count,
   output logic [IDXW-1:0]            fail_idx,
   output logic [XLEN-1:0]            fail_actual,
   output logic [2:0]                 dbg_state
);

   localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0]   CYC_LAST = CW'(MAX_CYCLES - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_CHECKS - 1);
   localparam logic [IDXW-1:0] IDX_NONE = IDXW'(NUM_CHECKS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_RD   = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cyc;
   logic [IDXW-1:0] idx;
   logic [XLEN-1:0] cur_val;
   logic            cmp_now;
   logic            last;
   logic            mismatch;
   logic            run_exit;

   assign cur_val   = chk_val[idx*XLEN +: XLEN];
   // With a registered read port the data for idx is only valid one cycle after RD.
   assign cmp_now   = (RD_LAT == 0) ? (state == S_RD) : (state == S_WAIT);
   assign last      = (idx == IDX_LAST);
   assign mismatch  = (rf_rdata != cur_val);
   assign run_exit  = halt || (cyc == CYC_LAST);
   assign busy      = (state == S_RUN) || (state == S_RD) || (state == S_WAIT);
   assign done      = (state == S_DONE);
   assign dbg_state = state;

   always_comb begin
      rf_raddr = '0;
      if ((state == S_RD) || (state == S_WAIT)) begin
         rf_raddr = chk_reg[idx*AW +: AW];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (run_exit) state_nxt = S_RD;
         end
         S_RD: begin
            if (RD_LAT != 0) state_nxt = S_WAIT;
            else             state_nxt = last ? S_DONE : S_RD;
         end
         S_WAIT: begin
            state_nxt = last ? S_DONE : S_RD;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc         <= '0;
         idx         <= '0;
         err_count   <= '0;
         fail_idx    <= IDX_NONE;
         fail_actual <= '0;
         pass        <= 1'b0;
         timed_out   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  cyc         <= '0;
                  idx         <= '0;
                  err_count   <= '0;
                  fail_idx    <= IDX_NONE;
                  fail_actual <= '0;
                  pass        <= 1'b0;
                  timed_out   <= 1'b0;
               end
            end
            S_RUN: begin
               if (run_exit) begin
                  idx       <= '0;
                  timed_out <= !halt;
               end else begin
                  cyc <= cyc + CW'(1);
               end
            end
            default: begin
               if (cmp_now) begin
                  if (mismatch) begin
                     if (err_count != IDX_NONE) err_count <= err_count + IDXW'(1);
                     if (err_count == '0) begin
                        fail_idx    <= idx;
                        fail_actual <= rf_rdata;
                     end
                  end
                  if (last) pass <= (err_count == '0) && !mismatch;
                  else      idx  <= idx + IDXW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_selfcheck_engine.sv
// Bench for reg_selfcheck_engine: a registered-read (RD_LAT=1) and a combinational-read
// (RD_LAT=0) instance share stimulus; results are predicted from the table and register model.
module tb_reg_selfcheck_engine;

   localparam int XLEN = 64;
   localparam int NUM  = 5;
   localparam int AW   = 5;
   localparam int MAXC = 500;
   localparam int IDXW = $clog2(NUM + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0;
   logic                 halt = 1'b0;
   logic [NUM*AW-1:0]    chk_reg = '0;
   logic [NUM*XLEN-1:0]  chk_val = '0;
   logic [AW-1:0]        raddr1, raddr0;
   logic [XLEN-1:0]      rdata1 = '0;
   logic [XLEN-1:0]      rdata0;
   logic                 busy1, done1, pass1, to1;
   logic                 busy0, done0, pass0, to0;
   logic [IDXW-1:0]      err1, fidx1, err0, fidx0;
   logic [XLEN-1:0]      fact1, fact0;
   logic [2:0]           dbg1, dbg0;

   logic [XLEN-1:0]      regs [32];
   logic [AW-1:0]        tbl_reg [NUM];
   logic [XLEN-1:0]      tbl_val [NUM];
   logic [AW-1:0]        exp_q [$];
   int                   n_checks = 0;
   int                   n_fail = 0;

   always #5 clk = ~clk;

   // Core register file model: one-cycle read for dut1, combinational read for dut0.
   always @(posedge clk) rdata1 <= regs[raddr1];
   always_comb rdata0 = regs[raddr0];

   reg_selfcheck_engine #(.XLEN(XLEN), .NUM_CHECKS(NUM), .AW(AW), .MAX_CYCLES(MAXC), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .chk_reg(chk_reg), .chk_val(chk_val),
      .rf_raddr(raddr1), .rf_rdata(rdata1), .busy(busy1), .done(done1), .pass(pass1),
      .timed_out(to1), .err_count(err1), .fail_idx(fidx1), .fail_actual(fact1), .dbg_state(dbg1)
   );

   reg_selfcheck_engine #(.XLEN(XLEN), .NUM_CHECKS(NUM), .AW(AW), .MAX_CYCLES(MAXC), .RD_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .chk_reg(chk_reg), .chk_val(chk_val),
      .rf_raddr(raddr0), .rf_rdata(rdata0), .busy(busy0), .done(done0), .pass(pass0),
      .timed_out(to0), .err_count(err0), .fail_idx(fidx0), .fail_actual(fact0), .dbg_state(dbg0)
   );

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic pack_table();
      for (int i = 0; i < NUM; i++) begin
         chk_reg[i*AW +: AW]     = tbl_reg[i];
         chk_val[i*XLEN +: XLEN] = tbl_val[i];
      end
   endtask

   task automatic load_defaults();
      for (int r = 0; r < 32; r++) regs[r] = {$urandom, $urandom};
      regs[6] = 64'd10; regs[7] = 64'd10; regs[8] = 64'd36; regs[9] = 64'd0; regs[11] = 64'd0;
      tbl_reg[0] = 5'd6;  tbl_val[0] = 64'd10;
      tbl_reg[1] = 5'd7;  tbl_val[1] = 64'd10;
      tbl_reg[2] = 5'd8;  tbl_val[2] = 64'd36;
      tbl_reg[3] = 5'd9;  tbl_val[3] = 64'd0;
      tbl_reg[4] = 5'd11; tbl_val[4] = 64'd0;
   endtask

   // Reference: walk the table against the register model, count mismatches, note the first.
   task automatic model(output int e_err, output int e_idx, output logic [XLEN-1:0] e_act);
      logic [XLEN-1:0] actual;
      e_err = 0; e_idx = NUM; e_act = '0;
      for (int i = 0; i < NUM; i++) begin
         actual = regs[tbl_reg[i]];
         if (actual !== tbl_val[i]) begin
            if (e_err == 0) begin
               e_idx = i;
               e_act = actual;
            end
            e_err++;
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".busy"}, busy1, 0);
      check({tag, ".done"}, done1, 0);
      check({tag, ".pass"}, pass1, 0);
      check({tag, ".timed_out"}, to1, 0);
      check({tag, ".err_count"}, err1, 0);
      check({tag, ".fail_idx"}, fidx1, NUM);
      check({tag, ".fail_actual"}, fact1, 0);
      check({tag, ".rf_raddr"}, raddr1, 0);
      check({tag, ".busy0"}, busy0, 0);
      check({tag, ".fail_idx0"}, fidx0, NUM);
   endtask

   // halt_at: cycle after start at which halt is sampled high (0 = never).
   task automatic run_case(input string tag, input int halt_at, input bit poke_start);
      int run_len, d1, d0, e_err, e_idx;
      logic e_to;
      logic [XLEN-1:0] e_act;
      pack_table();
      model(e_err, e_idx, e_act);
      if (halt_at >= 1 && halt_at <= MAXC) begin
         run_len = halt_at; e_to = 1'b0;
      end else begin
         run_len = MAXC; e_to = 1'b1;
      end
      exp_q.delete();
      for (int i = 0; i < NUM; i++) exp_q.push_back(tbl_reg[i]);

      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      check({tag, ".start_done_clr"}, done1, 0);
      check({tag, ".start_busy"}, busy1, 1);
      check({tag, ".start_err_clr"}, err1, 0);
      check({tag, ".start_fidx_clr"}, fidx1, NUM);
      check({tag, ".start_fact_clr"}, fact1, 0);
      @(negedge clk); start = 1'b0;

      d1 = -1; d0 = -1;
      for (int n = 1; n <= MAXC + 4*NUM + 20; n++) begin
         halt  = (n == halt_at);
         start = poke_start && (n == 5);
         @(posedge clk); #1;
         if (n >= run_len && n < run_len + NUM && exp_q.size() > 0)
            check({tag, ".raddr0_seq"}, raddr0, exp_q.pop_front());
         if (done1 && d1 < 0) d1 = n;
         if (done0 && d0 < 0) d0 = n;
         if (d1 >= 0 && d0 >= 0) break;
      end
      halt = 1'b0; start = 1'b0;

      check({tag, ".done_at1"}, d1, run_len + 2*NUM);
      check({tag, ".done_at0"}, d0, run_len + NUM);
      check({tag, ".pass1"}, pass1, (e_err == 0));
      check({tag, ".timed_out1"}, to1, e_to);
      check({tag, ".err_count1"}, err1, e_err);
      check({tag, ".fail_idx1"}, fidx1, e_idx);
      check({tag, ".fail_actual1"}, fact1, e_act);
      check({tag, ".pass0"}, pass0, (e_err == 0));
      check({tag, ".timed_out0"}, to0, e_to);
      check({tag, ".err_count0"}, err0, e_err);
      check({tag, ".fail_idx0"}, fidx0, e_idx);
      check({tag, ".fail_actual0"}, fact0, e_act);
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".done_held"}, done1, 1);
      check({tag, ".busy_in_done"}, busy1, 0);
   endtask

   task automatic reset_mid();
      load_defaults();
      regs[6] = 64'd3;
      pack_table();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; halt = 1'b1;
      @(negedge clk); halt = 1'b0;
      repeat (2) @(negedge clk);
      check("rstmid.pre_busy", busy1, 1);
      check("rstmid.pre_err", err1, 1);
      rst = 1'b0;
      #1;
      check_reset_values("rstmid");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstmid.stays_idle", busy1, 0);
   endtask

   initial begin
      load_defaults();
      pack_table();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk); rst = 1'b1;

      load_defaults();
      run_case("t1_timeout_pass", 0, 1'b0);
      load_defaults(); regs[8] = 64'd35;
      run_case("t2_one_err", 0, 1'b0);
      load_defaults();
      run_case("t3_halt20", 20, 1'b0);
      load_defaults(); regs[6] = 64'd0; regs[9] = 64'd7;
      run_case("t4_two_err", 0, 1'b0);
      load_defaults();
      run_case("t5_start_ignored", 0, 1'b1);
      load_defaults();
      run_case("halt_at_budget", MAXC, 1'b0);
      load_defaults(); regs[11] = 64'd1;
      run_case("halt_at_1", 1, 1'b0);
      reset_mid();
      load_defaults(); regs[7] = 64'd0;
      run_case("after_reset", 30, 1'b0);

      for (int k = 0; k < 8; k++) begin
         for (int r = 0; r < 32; r++) regs[r] = {$urandom, $urandom};
         for (int i = 0; i < NUM; i++) begin
            tbl_reg[i] = AW'($urandom_range(0, 31));
            tbl_val[i] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) regs[tbl_reg[i]] = tbl_val[i];
         end
         run_case($sformatf("rand%0d", k), $urandom_range(1, 60), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
